// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
//   arb_state_e : arbiter FSM states
//   NREQ_D      : default number of requesters
//   WIDTH_D     : default data width (must equal the cir_fifo width)
//   BURST_D     : default maximum accepted beats per grant
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int unsigned NREQ_D  = 4;
   localparam int unsigned WIDTH_D = 8;
   localparam int unsigned BURST_D = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select.
// Scans ptr+1, ptr+2, ... modulo NREQ and returns the first requester that is
// active and not masked. The scan wraps back to ptr itself last.
//   req   : request vector
//   ptr   : index of the most recently served requester
//   mask  : requesters to ignore for this pick
//   valid : at least one eligible requester
//   idx   : index of the winner (0 when valid is low)
module rr_picker #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic [NREQ-1:0] mask,
   output logic            valid,
   output logic [PW-1:0]   idx
);

   logic [NREQ-1:0] req_eff;

   assign req_eff = req & ~mask;

   // Walk the priority order backwards so the nearest candidate after ptr is
   // the last one written and therefore wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = int'(NREQ); i >= 1; i--) begin
         int cand;
         cand = (int'(ptr) + i) % int'(NREQ);
         if (req_eff[cand]) begin
            valid = 1'b1;
            idx   = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one cir_fifo write port among NREQ
// producers. Each grant is capped at BURST accepted beats; a full FIFO stalls
// the current owner without revoking its grant.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   req          : per-requester request, held while the requester has data
//   req_data     : per-requester data words
//   gnt          : registered one-hot grant
//   fifo_full    : cir_fifo full flag
//   fifo_wr      : write strobe to cir_fifo
//   fifo_wr_data : write data to cir_fifo
//   owner        : index of the current/last granted requester
//   busy         : high while a grant is held
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_D,
   parameter int unsigned width = WIDTH_D,
   parameter int unsigned BURST = BURST_D
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [width-1:0]        req_data [NREQ],
   output logic [NREQ-1:0]         gnt,
   input  logic                    fifo_full,
   output logic                    fifo_wr,
   output logic [width-1:0]        fifo_wr_data,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] LastBeat = CW'(BURST - 1);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            busy_q, busy_d;

   logic            accept;
   logic            owner_req;
   logic            last_beat;
   logic            release_now;
   logic [PW-1:0]   pick_ptr;
   logic [NREQ-1:0] pick_mask;
   logic            pick_valid;
   logic [PW-1:0]   pick_idx;

   // gnt is one-hot, so this is req[owner] gated by the grant and full flag.
   assign accept      = (|(gnt_q & req)) & ~fifo_full;
   assign owner_req   = req[owner_q];
   assign last_beat   = (beat_cnt_q == LastBeat);
   assign release_now = (state_q == GRANT) && ((accept && last_beat) || !owner_req);

   // While idle, scan from the last served requester; while granting, the
   // pick is only used on release, where the pointer becomes the owner.
   always_comb begin
      pick_ptr  = (state_q == IDLE) ? rr_ptr_q : owner_q;
      pick_mask = '0;
      if ((state_q == GRANT) && !owner_req) begin
         pick_mask[owner_q] = 1'b1;
      end
   end

   rr_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_picker (
      .req   (req),
      .ptr   (pick_ptr),
      .mask  (pick_mask),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d         = GRANT;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               owner_d         = pick_idx;
               beat_cnt_d      = '0;
               busy_d          = 1'b1;
            end
         end

         GRANT: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
            if (release_now) begin
               rr_ptr_d = owner_q;
               // Hand over at the same edge so back-to-back grants have no bubble.
               if (pick_valid) begin
                  gnt_d           = '0;
                  gnt_d[pick_idx] = 1'b1;
                  owner_d         = pick_idx;
                  beat_cnt_d      = '0;
               end else begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  beat_cnt_d = '0;
                  busy_d     = 1'b0;
               end
            end
         end

         default: begin
            state_d    = IDLE;
            gnt_d      = '0;
            beat_cnt_d = '0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= PW'(NREQ - 1);
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt          = gnt_q;
   assign owner        = owner_q;
   assign busy         = busy_q;
   assign fifo_wr      = accept;
   assign fifo_wr_data = busy_q ? req_data[owner_q] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Producers present base+sent words and
// drop req once their word budget is used; a 16-deep FIFO model records writes.
module tb_fifo_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] req_data [4];
   logic [3:0] gnt;
   logic       fifo_full;
   logic       fifo_wr;
   logic [7:0] fifo_wr_data;
   logic [1:0] owner;
   logic       busy;

   logic [3:0] en;
   logic       force_full;
   int         sent [4];
   int         limit [4];
   logic [7:0] mem [256];
   int         wr_ptr;
   int         rd_ptr;
   int         overflow;
   int         checks;
   int         failures;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NREQ  (4),
      .width (8),
      .BURST (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .fifo_full    (fifo_full),
      .fifo_wr      (fifo_wr),
      .fifo_wr_data (fifo_wr_data),
      .owner        (owner),
      .busy         (busy)
   );

   assign fifo_full = force_full || ((wr_ptr - rd_ptr) >= 16);

   // Requester i sends words A0/B0/C0/D0 + running index.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req[i]      = en[i] && (sent[i] < limit[i]);
         req_data[i] = 8'(32'hA0 + 16 * i + sent[i]);
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (gnt[i] && req[i] && !fifo_full) sent[i] <= sent[i] + 1;
      end
      if (fifo_wr) begin
         if (fifo_full) overflow <= overflow + 1;
         mem[wr_ptr % 256] <= fifo_wr_data;
         wr_ptr <= wr_ptr + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
         failures++;
         $display("FAIL reset_state gnt=%b busy=%b owner=%0d exp 0000/0/0", gnt, busy, owner);
      end
      checks++;
      if (fifo_wr !== 1'b0 || fifo_wr_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_wr wr=%b data=%h exp 0/00", fifo_wr, fifo_wr_data);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 20; c++) begin
         step();
         checks++;
         if (busy !== 1'b0 || fifo_wr !== 1'b0 || fifo_wr_data !== 8'h00) begin
            failures++;
            $display("FAIL idle cyc=%0d busy=%b wr=%b data=%h exp 0/0/00",
                     c, busy, fifo_wr, fifo_wr_data);
         end
      end
   endtask

   task automatic test_single();
      int         s0;
      int         wp;
      logic       exp_wr;
      logic [7:0] exp_d;
      s0 = sent[0];
      wp = wr_ptr;
      limit[0] = s0 + 6;
      en = 4'b0001;
      for (int k = 1; k <= 7; k++) begin
         step();
         exp_wr = (k <= 6);
         checks++;
         if (gnt !== 4'b0001 || fifo_wr !== exp_wr) begin
            failures++;
            $display("FAIL single_cyc%0d gnt=%b wr=%b exp 0001/%b", k, gnt, fifo_wr, exp_wr);
         end
         if (k == 4) begin
            checks++;
            if (dut.beat_cnt_q !== 3'd3) begin
               failures++;
               $display("FAIL single_beat3 beat_cnt=%0d exp 3", dut.beat_cnt_q);
            end
         end
         if (k == 5) begin
            checks++;
            if (dut.beat_cnt_q !== 3'd0) begin
               failures++;
               $display("FAIL single_regrant beat_cnt=%0d exp 0", dut.beat_cnt_q);
            end
         end
      end
      step();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_release gnt=%b busy=%b exp 0000/0", gnt, busy);
      end
      checks++;
      if (wr_ptr - wp != 6) begin
         failures++;
         $display("FAIL single_count writes=%0d exp 6", wr_ptr - wp);
      end
      for (int j = 0; j < 6; j++) begin
         exp_d = 8'(32'hA0 + s0 + j);
         checks++;
         if (mem[(wp + j) % 256] !== exp_d) begin
            failures++;
            $display("FAIL single_data%0d got=%h exp=%h", j, mem[(wp + j) % 256], exp_d);
         end
      end
      en = 4'b0000;
      rd_ptr = wr_ptr;
   endtask

   task automatic test_round_robin();
      int         s [4];
      int         wp;
      int         r;
      logic [3:0] exp_g;
      logic       exp_wr;
      logic [7:0] exp_d;
      pulse_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         s[i] = sent[i];
         limit[i] = sent[i] + 100;
      end
      wp = wr_ptr;
      en = 4'b1111;
      for (int k = 1; k <= 17; k++) begin
         step();
         exp_g  = (k <= 16) ? 4'(1 << ((k - 1) / 4)) : 4'b0001;
         exp_wr = (k <= 16);
         checks++;
         if (gnt !== exp_g || fifo_wr !== exp_wr) begin
            failures++;
            $display("FAIL rr_cyc%0d gnt=%b wr=%b exp %b/%b", k, gnt, fifo_wr, exp_g, exp_wr);
         end
      end
      checks++;
      if (fifo_full !== 1'b1) begin
         failures++;
         $display("FAIL rr_full fifo_full=%b exp 1", fifo_full);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (gnt !== 4'b0001 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL rr_hold%0d gnt=%b wr=%b exp 0001/0", c, gnt, fifo_wr);
         end
      end
      for (int j = 0; j < 16; j++) begin
         r = j / 4;
         exp_d = 8'(32'hA0 + 16 * r + s[r] + (j % 4));
         checks++;
         if (mem[(wp + j) % 256] !== exp_d) begin
            failures++;
            $display("FAIL rr_data%0d got=%h exp=%h", j, mem[(wp + j) % 256], exp_d);
         end
      end
      en = 4'b0000;
      step();
      rd_ptr = wr_ptr;
   endtask

   task automatic test_full_stall();
      int         s1;
      int         wp;
      logic [7:0] exp_d;
      s1 = sent[1];
      wp = wr_ptr;
      limit[1] = s1 + 4;
      en = 4'b0010;
      step();
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL stall_grant gnt=%b exp 0010", gnt);
      end
      step();
      step();
      force_full = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         checks++;
         if (fifo_wr !== 1'b0 || gnt !== 4'b0010 || dut.beat_cnt_q !== 3'd2) begin
            failures++;
            $display("FAIL stall_hold%0d wr=%b gnt=%b beat_cnt=%0d exp 0/0010/2",
                     c, fifo_wr, gnt, dut.beat_cnt_q);
         end
      end
      force_full = 1'b0;
      #1;
      checks++;
      if (fifo_wr !== 1'b1) begin
         failures++;
         $display("FAIL stall_resume wr=%b exp 1", fifo_wr);
      end
      step();
      step();
      step();
      checks++;
      if (gnt !== 4'b0000 || wr_ptr - wp != 4) begin
         failures++;
         $display("FAIL stall_done gnt=%b writes=%0d exp 0000/4", gnt, wr_ptr - wp);
      end
      for (int j = 0; j < 4; j++) begin
         exp_d = 8'(32'hB0 + s1 + j);
         checks++;
         if (mem[(wp + j) % 256] !== exp_d) begin
            failures++;
            $display("FAIL stall_data%0d got=%h exp=%h", j, mem[(wp + j) % 256], exp_d);
         end
      end
      en = 4'b0000;
      rd_ptr = wr_ptr;
   endtask

   task automatic test_owner_drop();
      int         s0;
      int         wp;
      logic [7:0] exp_d;
      pulse_reset();
      step();
      s0 = sent[0];
      wp = wr_ptr;
      limit[0] = s0 + 2;
      limit[2] = sent[2] + 100;
      en = 4'b0101;
      step();
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL drop_first gnt=%b exp 0001", gnt);
      end
      step();
      step();
      step();
      checks++;
      if (gnt !== 4'b0100 || owner !== 2'd2 || dut.beat_cnt_q !== 3'd0) begin
         failures++;
         $display("FAIL drop_handover gnt=%b owner=%0d beat_cnt=%0d exp 0100/2/0",
                  gnt, owner, dut.beat_cnt_q);
      end
      checks++;
      if (wr_ptr - wp != 2) begin
         failures++;
         $display("FAIL drop_count writes=%0d exp 2", wr_ptr - wp);
      end
      for (int j = 0; j < 2; j++) begin
         exp_d = 8'(32'hA0 + s0 + j);
         checks++;
         if (mem[(wp + j) % 256] !== exp_d) begin
            failures++;
            $display("FAIL drop_data%0d got=%h exp=%h", j, mem[(wp + j) % 256], exp_d);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      step();
      step();
      checks++;
      if (busy !== 1'b1 || gnt !== 4'b0100) begin
         failures++;
         $display("FAIL midrst_pre busy=%b gnt=%b exp 1/0100", busy, gnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || fifo_wr !== 1'b0 || owner !== 2'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_async gnt=%b wr=%b owner=%0d busy=%b exp 0000/0/0/0",
                  gnt, fifo_wr, owner, busy);
      end
      limit[1] = sent[1] + 100;
      limit[3] = sent[3] + 100;
      en = 4'b1010;
      #1;
      rst = 1'b1;
      step();
      checks++;
      if (gnt !== 4'b0010 || owner !== 2'd1) begin
         failures++;
         $display("FAIL midrst_first gnt=%b owner=%0d exp 0010/1", gnt, owner);
      end
      en = 4'b0000;
      step();
      step();
      rd_ptr = wr_ptr;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      en         = 4'b0000;
      force_full = 1'b0;
      rd_ptr     = 0;
      for (int i = 0; i < 4; i++) limit[i] = 0;
      test_reset();
      test_idle();
      test_single();
      test_round_robin();
      test_full_stall();
      test_owner_drop();
      test_reset_mid_burst();
      checks++;
      if (overflow != 0) begin
         failures++;
         $display("FAIL overflow writes_while_full=%0d exp 0", overflow);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
